// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and helpers for the 7-segment display blocks
package seg_pkg;
  localparam int DEF_REFRESH_DIV = 50000;
  localparam int DEF_BLANK_CYC = 2;
  localparam int MAX_DIGITS = 16;
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/seg_prescaler.sv
// seg_prescaler: modulo-DIV counter with enable and terminal-count pulse
module seg_prescaler import seg_pkg::*; #(
  parameter int DIV = DEF_REFRESH_DIV
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic [clog2(DIV)-1:0]  count,
  output logic                   tc
);
  localparam int W = clog2(DIV);
  assign tc = en && (count == W'(DIV - 1));
  always_ff @(posedge clk) begin
    if (!rst_n) count <= '0;
    else if (tc) count <= '0;
    else if (en) count <= count + 1'b1;
  end
endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: common-anode multi-digit 7-segment scan driver with
// frame-boundary commit of pending values and leading-zero blanking
module seg_scan_mux import seg_pkg::*; #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int BLANK_CYC   = DEF_BLANK_CYC
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          Enable,
  input  logic                          Load,
  input  logic [4*NUM_DIGITS-1:0]       Value,
  input  logic [NUM_DIGITS-1:0]         DpMask,
  input  logic                          BlankLZ,
  output logic [3:0]                    Nibble,
  output logic [NUM_DIGITS-1:0]         AnodeN,
  output logic                          DpN,
  output logic [clog2(NUM_DIGITS)-1:0]  DigitIdx,
  output logic                          FrameTick,
  output logic                          Pending
);
  localparam int PW = clog2(REFRESH_DIV);
  localparam int DW = clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] OFF = ANODE_OFF[NUM_DIGITS-1:0];
  logic [PW-1:0] ps;
  logic tc, wrap, show;
  logic [4*NUM_DIGITS-1:0] pend_val, disp_val;
  logic [NUM_DIGITS-1:0] pend_dp, disp_dp, zero_above;
  logic [3:0] cur_nib;

  seg_prescaler #(.DIV(REFRESH_DIV)) u_pre (
    .clk  (Clk),
    .rst_n(Reset_n),
    .en   (Enable),
    .count(ps),
    .tc   (tc)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      DigitIdx  <= '0;
      FrameTick <= 1'b0;
    end else begin
      FrameTick <= wrap;
      if (tc) DigitIdx <= wrap ? '0 : DigitIdx + 1'b1;
    end
  end

  // commit uses the pending contents from before this edge's Load
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pend_val <= '0;
      pend_dp  <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
      Pending  <= 1'b0;
    end else begin
      if (Load) begin
        pend_val <= Value;
        pend_dp  <= DpMask;
      end
      if (wrap && Pending) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
      end
      Pending <= Load || (Pending && !wrap);
    end
  end

  // zero_above[i]: nibbles N-1..i of the display are all zero
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_lz
    if (d == NUM_DIGITS - 1) begin : g_top
      assign zero_above[d] = (disp_val[4*d +: 4] == 4'd0);
    end else begin : g_rest
      assign zero_above[d] = (disp_val[4*d +: 4] == 4'd0) && zero_above[d+1];
    end
  end

  always_comb begin
    wrap    = tc && (DigitIdx == DW'(NUM_DIGITS - 1));
    cur_nib = disp_val[{DigitIdx, 2'b00} +: 4];
    show    = Enable && (ps >= PW'(BLANK_CYC)) &&
              !(BlankLZ && (DigitIdx != '0) && zero_above[DigitIdx]);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      AnodeN <= OFF;
      Nibble <= 4'd0;
      DpN    <= 1'b1;
    end else begin
      AnodeN <= show ? ~(NUM_DIGITS'(1) << DigitIdx) : OFF;
      Nibble <= show ? cur_nib : 4'd0;
      DpN    <= !(show && disp_dp[DigitIdx]);
    end
  end
endmodule
